// File: rtl/nn_stream_pkg.sv
// Shared types and default widths for the accelerator word-stream blocks.
package nn_stream_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } tx_state_e;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO whose head entry is a register, so the stream side sees
// registered data and a registered non-empty flag.
module stream_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   occ
);
  logic [W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word goes behind whatever remains.
          if (occ == 2'd1) head <= push_data;
          else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = (occ == 2'd2);
  assign empty = (occ == 2'd0);
endmodule

// File: rtl/stream_burst_tx.sv
// Burst reader: fetches burst_len words from a 1-cycle-latency memory starting
// at base_addr and streams them out with valid/ready flow control.
//
// Handshake: a word moves when valid_out && ready_in at a rising edge. Once
// valid_out is high, valid_out/data_out/last_out hold until that transfer;
// valid_out is a register decode and never depends on ready_in.
module stream_burst_tx
  import nn_stream_pkg::*;
#(
  parameter int DATA_W = nn_stream_pkg::DATA_W,
  parameter int ADDR_W = nn_stream_pkg::ADDR_W,
  parameter int LEN_W  = nn_stream_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              last_out,
  input  logic              ready_in,
  output tx_state_e         state
);
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  sent;
  logic              inflight;
  logic              inflight_last;
  logic              pop;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        budget;
  logic [DATA_W:0]   head;

  assign pop = valid_out && ready_in;

  // Words the buffer will hold after this edge if no new read is issued.
  assign budget    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign mem_rd_en = (state == RUN) && (issued < len_q) && (budget < 3'd2);
  assign mem_rd_addr = base_q + ADDR_W'(issued);

  assign fifo_push = inflight && (!fifo_full || pop);

  stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data ({inflight_last, mem_rd_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occ       (occ)
  );

  assign valid_out = !fifo_empty;
  assign data_out  = head[DATA_W-1:0];
  assign last_out  = valid_out && head[DATA_W];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued        <= '0;
      sent          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= mem_rd_en;
      // The last flag travels with the read so it lands on the right buffer entry.
      inflight_last <= mem_rd_en && (issued == len_q - LEN_W'(1));
      if (mem_rd_en) issued <= issued + LEN_W'(1);
      if (pop)       sent   <= sent + LEN_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              state  <= RUN;
              base_q <= base_addr;
              len_q  <= burst_len;
              issued <= '0;
              sent   <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issued == len_q) state <= FLUSH;
        end
        FLUSH: begin
          if (pop && (sent == len_q - LEN_W'(1))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_burst_tx.sv
// Scoreboard bench for stream_burst_tx: bursts queue expected words/addresses,
// a negedge monitor compares whatever the DUT presents.
module tb_stream_burst_tx;
  import nn_stream_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          last_out;
  logic          ready_in = 1'b1;
  tx_state_e     state;

  stream_burst_tx dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .base_addr   (base_addr),
    .burst_len   (burst_len),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .last_out    (last_out),
    .ready_in    (ready_in),
    .state       (state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : DW'($urandom);

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [AW-1:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;
  bit last_pending = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h required %s", name, act, req);
  endtask

  // ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: ready_in = 1'b1;
      1: begin
        ready_in  = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 3;
      end
      default: ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge clk) begin
    if (!rstn) begin
      rd_cnt   <= 0;
      xfer_cnt <= 0;
    end else begin
      rd_cnt   <= rd_cnt + (mem_rd_en ? 1 : 0);
      xfer_cnt <= xfer_cnt + ((valid_out && ready_in) ? 1 : 0);
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rstn) begin
      logic lv;
      if (last_pending) chk("done_after_last", done, 1);
      last_pending = 0;
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", valid_out, 1);
        chk("stall_data", data_out, prev_data);
        chk("stall_last", last_out, prev_last);
      end
      chk("occupancy_le2", (rd_cnt - xfer_cnt) <= 2, 1);
      if (mem_rd_en) begin
        if (addr_q.size() == 0) fail("unexpected_read", mem_rd_addr, "no read");
        else chk("rd_addr", mem_rd_addr, addr_q.pop_front());
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) fail("unexpected_word", data_out, "no word");
        else begin
          chk("data", data_out, exp_q.pop_front());
          lv = exp_last_q.pop_front();
          chk("last", last_out, lv);
          if (lv) last_pending = 1;
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_last  = last_out;
    end else begin
      prev_stall   = 0;
      last_pending = 0;
    end
  end

  // driver
  task automatic run_burst(input logic [AW-1:0] b, input int len, input int mode, input bit poke);
    int d0;
    int x0;
    int to;
    rdy_mode = mode;
    d0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_q.push_back(mem[a]);
      exp_last_q.push_back(i == len - 1);
      addr_q.push_back(a);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; burst_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    x0 = xfer_cnt;
    @(negedge clk);
    if (len == 0) begin
      chk("zero_len_done", done, 1);
      chk("zero_len_busy", busy, 0);
    end else begin
      chk("busy_after_start", busy, 1);
      chk("rd_en_first_cycle", mem_rd_en, 1);
      @(negedge clk);
      chk("valid_not_yet", valid_out, 0);
      @(negedge clk);
      chk("valid_at_latency", valid_out, 1);
      if (mode == 0 && !poke) begin
        repeat (len) @(negedge clk);
        chk("back_to_back", xfer_cnt - x0, len);
      end
    end
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = ~b; burst_len = LW'(len + 3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    to = 0;
    while ((busy || exp_q.size() != 0) && to < 4000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 4000) fail("burst_timeout", to, "burst completion");
    @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("addr_q_empty", addr_q.size(), 0);
  endtask

  task automatic reset_mid_burst();
    logic [AW-1:0] b;
    int d0;
    int x0;
    int to;
    b = AW'($urandom);
    rdy_mode = 0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_q.push_back(mem[a]);
      exp_last_q.push_back(i == 7);
      addr_q.push_back(a);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; burst_len = LW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    x0 = xfer_cnt;
    to = 0;
    while ((xfer_cnt - x0) < 2 && to < 100) begin
      @(posedge clk); #1;
      to++;
    end
    if (to >= 100) fail("reset_wait_timeout", to, "2 transfers");
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    addr_q.delete();
    @(negedge clk);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_en", mem_rd_en, 0);
    repeat (4) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle_valid", valid_out, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i * 3);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", valid_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_last", last_out, 0);
    chk("reset_state", state, IDLE);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid_out, 0);
      chk("idle_done", done, 0);
      chk("idle_rd_en", mem_rd_en, 0);
    end

    run_burst(AW'(10'h010), 4, 0, 0);

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run_burst(AW'($urandom), 6, 1, 0);
    run_burst(AW'(10'h3FE), 4, 0, 0);
    run_burst(AW'($urandom), 0, 0, 0);
    run_burst(AW'($urandom), 8, 1, 1);
    reset_mid_burst();
    run_burst(AW'($urandom), 5, 0, 0);
    for (int k = 0; k < 6; k++) run_burst(AW'($urandom), $urandom_range(1, 40), 2, 0);
    run_burst(AW'($urandom), $urandom_range(1, 40), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    fail("watchdog", 0, "bench completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
